// File: rtl/fifo_burst_reader_pkg.sv
// fifo_burst_reader_pkg: state encoding and sizing shared by the burst reader and its output buffer.
package fifo_burst_reader_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;
   localparam int OBUF_DEPTH = 2;
   localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry in-order stream buffer; head entry drives the output, push and pop may coincide.
module skid_buf2 import fifo_burst_reader_pkg::*; #(
   parameter int DW = DEF_DATA_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] head,
   output logic          valid,
   output logic [1:0]    count
);
   logic [DW-1:0] tail;
   logic          full;
   assign full  = count == 2'(OBUF_DEPTH);
   assign valid = count != 2'd0;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         // head only moves on a pop or when filling an empty buffer, so it holds during stalls
         if (pop ? (full || push) : (push && !valid)) head <= (pop && full) ? tail : din;
         if (push && (full || (valid && !pop))) tail <= din;
         count <= count + 2'(push) - 2'(pop);
      end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains burst_len words from a registered-output FIFO onto a valid/ready stream.
module fifo_burst_reader import fifo_burst_reader_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic              fifo_empt,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              done
);
   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
   state_t           state;
   logic [LEN_W-1:0] req_left, out_left;
   logic             rd_q, pop;
   logic [1:0]       buf_count;
   logic [2:0]       occ;
   assign pop     = m_valid && m_ready;
   // credit: buffered + in-flight - leaving this cycle must leave room for one more word
   assign occ     = {1'b0, buf_count} + {2'b0, rd_q} - {2'b0, pop};
   assign fifo_rd = state == RUN && !fifo_empt && req_left != '0 && occ < 3'(OBUF_DEPTH);
   assign m_last  = m_valid && out_left == ONE;
   assign busy    = state != IDLE;
   assign done    = state == DONE;
   skid_buf2 #(.DW(DATA_W)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_q),
      .pop   (pop),
      .din   (fifo_data),
      .head  (m_data),
      .valid (m_valid),
      .count (buf_count)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         req_left <= '0;
         out_left <= '0;
         rd_q     <= 1'b0;
      end else begin
         rd_q <= fifo_rd;
         case (state)
            IDLE:
               if (start) begin
                  req_left <= burst_len;
                  out_left <= burst_len;
                  state    <= burst_len != '0 ? RUN : DONE;
               end
            RUN, FLUSH: begin
               if (fifo_rd) req_left <= req_left - ONE;
               if (pop) out_left <= out_left - ONE;
               if ((pop && out_left == ONE) || (state == FLUSH && out_left == '0)) state <= DONE;
               else if (state == RUN && fifo_rd && req_left == ONE) state <= FLUSH;
            end
            DONE: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: FIFO stand-in, per-cycle stream model and directed burst scenarios.
module tb_fifo_burst_reader;
   localparam int DW = 32;
   localparam int LW = 8;
   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, m_ready = 1'b1;
   logic [LW-1:0] burst_len = '0;
   logic          fifo_empt, fifo_rd, m_valid, m_last, busy, done;
   logic [DW-1:0] fifo_data = '0, m_data;
   logic [DW-1:0] mem [256];
   int            wr_cnt = 0, fifo_pops = 0;
   int            checks = 0, errors = 0;

   fifo_burst_reader #(.DATA_W(DW), .LEN_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .burst_len (burst_len),
      .fifo_empt (fifo_empt),
      .fifo_data (fifo_data),
      .fifo_rd   (fifo_rd),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // FIFO: everything ever written lives in mem, reads advance fifo_pops with one cycle of latency
   assign fifo_empt = fifo_pops == wr_cnt;
   always @(posedge clk)
      if (fifo_rd && !fifo_empt) begin
         fifo_data <= mem[fifo_pops];
         fifo_pops <= fifo_pops + 1;
      end

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // model: a burst delivers the next burst_len FIFO words in order, last flagged, done one cycle after
   logic          m_act = 1'b0, m_dc = 1'b0, prev_stall = 1'b0, nxt;
   logic [DW-1:0] prev_data = '0;
   int            rd_idx = 0, remaining = 0, iss = 0, dlv = 0, m_len = 0;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         m_act = 1'b0; m_dc = 1'b0; prev_stall = 1'b0;
         rd_idx = fifo_pops; iss = 0; dlv = 0;
      end else begin
         chk("busy", busy, m_act || m_dc);
         chk("done", done, m_dc);
         if (!m_act) begin
            chk("idle_valid", m_valid, 1'b0);
            chk("idle_rd", fifo_rd, 1'b0);
         end else begin
            chk("in_flight", iss - dlv <= 2, 1'b1);
            chk("m_last", m_last, m_valid && remaining == 1);
            if (m_valid) chk($sformatf("m_data_w%0d", rd_idx), m_data, mem[rd_idx]);
            if (prev_stall) begin
               chk("hold_valid", m_valid, 1'b1);
               chk("hold_data", m_data, prev_data);
            end
            if (fifo_rd) begin
               iss++;
               chk("rd_limit", iss <= m_len, 1'b1);
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         nxt = 1'b0;
         if (m_act && m_valid && m_ready) begin
            rd_idx++; dlv++; remaining--;
            if (remaining == 0) begin
               m_act = 1'b0;
               nxt   = 1'b1;
            end
         end else if (!m_act && !m_dc && start) begin
            if (burst_len == 0) nxt = 1'b1;
            else begin
               m_act = 1'b1; remaining = int'(burst_len); m_len = int'(burst_len);
               iss = 0; dlv = 0;
            end
         end
         m_dc = nxt;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(logic [DW-1:0] d);
      mem[wr_cnt] = d;
      wr_cnt++;
   endtask

   task automatic go(int len);
      burst_len = LW'(len);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(string name, int bound, bit toggle);
      checks++;
      for (int i = 0; i < bound; i++) begin
         if (toggle) m_ready = (i % 4 == 0) || (i % 4 == 3);
         @(negedge clk);
         if (done) begin
            m_ready = 1'b1;
            tick();
            return;
         end
         tick();
      end
      errors++;
      m_ready = 1'b1;
      $display("FAIL %s timeout actual=no_done required=done", name);
   endtask

   initial begin
      logic [8:0] e_rd, e_v, e_d;
      int p0, n;
      e_rd = 9'b000011110;
      e_v  = 9'b001111000;
      e_d  = 9'b010000000;
      @(negedge clk);
      chk("rst_fifo_rd", fifo_rd, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_last", m_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_m_data", m_data, '0);
      tick();
      rst = 1'b0;
      tick();
      // four preloaded words at full rate: reads in cycles 1-4, words in 3-6, done in 7
      for (int i = 0; i < 4; i++) wr(DW'(32'hA0 + i));
      burst_len = 8'd4;
      start = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         chk($sformatf("t1_rd_c%0d", c), fifo_rd, e_rd[c]);
         chk($sformatf("t1_valid_c%0d", c), m_valid, e_v[c]);
         chk($sformatf("t1_last_c%0d", c), m_last, c == 6);
         chk($sformatf("t1_done_c%0d", c), done, e_d[c]);
         if (e_v[c]) chk($sformatf("t1_data_c%0d", c), m_data, DW'(32'hA0 + c - 3));
         tick();
         start = 1'b0;
      end
      chk("t1_fifo_empty", fifo_empt, 1'b1);
      // short burst leaves the excess words in the FIFO
      p0 = fifo_pops;
      for (int i = 0; i < 8; i++) wr(DW'(32'hB0 + i));
      go(3);
      wait_done("t2_done", 50, 1'b0);
      chk("t2_reads", DW'(fifo_pops - p0), DW'(3));
      chk("t2_left", DW'(wr_cnt - fifo_pops), DW'(5));
      // backpressure 1,0,0,1 drains the five leftovers
      go(5);
      wait_done("t3_done", 80, 1'b1);
      chk("t3_fifo_empty", fifo_empt, 1'b1);
      // FIFO runs dry after two words; the burst waits for two late writes
      wr(DW'(32'hC0));
      wr(DW'(32'hC1));
      go(4);
      repeat (10) tick();
      @(negedge clk);
      chk("t4_stall_busy", busy, 1'b1);
      chk("t4_stall_valid", m_valid, 1'b0);
      chk("t4_stall_rd", fifo_rd, 1'b0);
      tick();
      wr(DW'(32'hC2));
      wr(DW'(32'hC3));
      wait_done("t4_done", 30, 1'b0);
      // zero-length burst finishes without touching the FIFO
      burst_len = '0;
      start = 1'b1;
      @(negedge clk);
      chk("t5_done_c0", done, 1'b0);
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("t5_done_c1", done, 1'b1);
      chk("t5_busy_c1", busy, 1'b1);
      chk("t5_rd_c1", fifo_rd, 1'b0);
      tick();
      @(negedge clk);
      chk("t5_done_c2", done, 1'b0);
      chk("t5_busy_c2", busy, 1'b0);
      tick();
      // a second start while running is ignored
      wr(DW'(32'hD0));
      wr(DW'(32'hD1));
      p0 = fifo_pops;
      go(2);
      tick();
      burst_len = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t5b_done", 30, 1'b0);
      repeat (3) tick();
      chk("t5b_reads", DW'(fifo_pops - p0), DW'(2));
      chk("t5b_idle", busy, 1'b0);
      // asynchronous reset after two of six words
      for (int i = 0; i < 6; i++) wr(DW'(32'hE0 + i));
      go(6);
      n = 0;
      for (int i = 0; i < 40 && n < 2; i++) begin
         @(negedge clk);
         if (m_valid && m_ready) n++;
      end
      chk("t6_two_words", DW'(n), DW'(2));
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_rd", fifo_rd, 1'b0);
      chk("t6_rst_valid", m_valid, 1'b0);
      chk("t6_rst_last", m_last, 1'b0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_done", done, 1'b0);
      chk("t6_rst_data", m_data, '0);
      tick();
      rst = 1'b0;
      tick();
      p0 = fifo_pops;
      go(2);
      wait_done("t6_done", 30, 1'b0);
      chk("t6_reads", DW'(fifo_pops - p0), DW'(2));
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
